trap_sequencer: RTL and testbench
=================================

// Module: trap_sequencer
// PURPOSE
//   Sequences the decoder's ecall/uret/CSRRSI/CSRRCI strobes and up to 4 external IRQ lines
//   into PC redirects for the single-cycle RISC-V core.
//   Holds interrupt-enable state, per-source pending/in-service bits and a nested EPC stack.
//   Drives PC_SEL/TARGET into the next-PC mux alongside the Beq/Bne/BLTU/JAL/Jalr paths.
// PARAMETERS
//   NUM_IRQ    3             external sources, 1..4; index 0 = highest priority
//   VEC_BASE   32'h0000_0100 vector of IRQ 0; IRQ j vector = VEC_BASE + j*VEC_STRIDE
//   VEC_STRIDE 32'h0000_0010 spacing between IRQ vectors
//   ECALL_VEC  32'h0000_0080 ecall handler address
// PORTS
//   CLK        in  1        core clock, rising edge
//   RST        in  1        asynchronous, active-high reset
//   VALID      in  1        instruction retires this cycle; 0 = halt/stall
//   ecall      in  1        decoder ecall strobe
//   uret       in  1        decoder uret strobe
//   CSRRSI     in  1        decoder CSRRSI strobe
//   CSRRCI     in  1        decoder CSRRCI strobe
//   CSR_IMM    in  5        zimm field; [0]=IE, [NUM_IRQ:1]=MIE per source
//   NPC        in  32       datapath next PC for the retiring instruction (post-branch)
//   IRQ        in  NUM_IRQ  external requests, level; rising edge = request
//   PC_SEL     out 1        1 = next PC is TARGET (combinational)
//   TARGET     out 32       redirect address (combinational)
//   IE         out 1        global interrupt enable
//   MIE        out NUM_IRQ  per-source enable
//   PENDING    out NUM_IRQ  latched requests
//   IN_SERVICE out NUM_IRQ  sources currently on the stack
//   TRAP_OVF   out 1        sticky: trap dropped because the stack was full
// BEHAVIOUR
//   Reset:
//   - IE, MIE, PENDING, IN_SERVICE, TRAP_OVF and stack pointer SP are all 0.
//   - PC_SEL = 0.
//   - IRQ edge-detect history = 0.
//   Edge capture (every cycle, independent of VALID):
//   - Rising edge on IRQ[j] sets PENDING[j].
//   - A set on the same edge as a take of j wins: PENDING[j] stays 1.
//   Stack: depth NUM_IRQ+1.
//   - Each entry = {EPC[31:0], PIE, tag}; tag = IRQ index or ecall.
//   - SP ranges 0..NUM_IRQ+1.
//   Each VALID cycle, exactly one action is selected, in this priority order:
//   1) ecall:
//      - SP < max: push {NPC, IE, ecall}, IE <= 0, PC_SEL = 1, TARGET = ECALL_VEC.
//      - SP == max: no redirect, TRAP_OVF <= 1.
//   2) uret:
//      - SP > 0: pop; PC_SEL = 1, TARGET = EPC; IE <= PIE; clear IN_SERVICE[tag] if the tag is an IRQ.
//      - SP == 0: no-op, PC_SEL = 0.
//   3) IRQ take:
//      - Candidate j = lowest index with PENDING[j] & MIE[j], and IE = 1.
//      - j must also be below every index set in IN_SERVICE.
//      - Take: push {NPC, IE, j}; IE <= 0; PENDING[j] <= 0; IN_SERVICE[j] <= 1.
//      - Take drives PC_SEL = 1, TARGET = VEC_BASE + j*VEC_STRIDE.
//      - Stack full: no take, PENDING kept; TRAP_OVF is not set.
//   4) CSRRSI / CSRRCI:
//      - CSRRSI: IE |= IMM[0] and MIE |= IMM[NUM_IRQ:1].
//      - CSRRCI: IE &= ~IMM[0] and MIE &= ~IMM[NUM_IRQ:1].
//      - Takes effect from the next cycle.
//   Cycle rules:
//   - An IRQ is never taken in a cycle where ecall or uret redirects; it is re-evaluated next cycle with the updated IE.
//   - VALID = 0: PC_SEL = 0, and no state changes other than edge capture.
//   - Trap latency: IRQ edge at cycle t, PENDING set at t+1, redirect at t+1 if enabled.
//   - TARGET = 0 whenever PC_SEL = 0.
//   - RST mid-handler: stack is discarded, SP = 0, all state returns to reset values.
// CONFIGURATION
//   IRQ_SYNC_EN
//   - Defined: each IRQ bit passes a 2-flop synchronizer (reset to 0) before edge detect.
//   - Defined: capture latency is +2 cycles (PENDING set at t+3).
//   - Undefined: IRQ is edge-detected directly, and PENDING is set at t+1.
// TESTING
//   Reset: RST=1 mid-run -> all outputs 0, SP=0, PC_SEL=0.
//   ecall/uret: ecall with NPC=0x40 -> TARGET=0x80, IE=0; later uret -> TARGET=0x40, IE restored.
//   Enable and take: CSRRSI IMM=5'b01111, IRQ[1] rising edge, NPC=0x200
//     -> next cycle PC_SEL=1, TARGET=0x110, IN_SERVICE=3'b010, IE=0.
//   Nesting:
//   - In service of IRQ1 with IE re-enabled, IRQ0 edge -> TARGET=0x100.
//   - IRQ2 edge -> pending only; after both urets, IRQ2 is taken.
//   Collisions and limits:
//   - ecall and pending IRQ0 in the same cycle -> TARGET=0x80, PENDING[0] stays 1.
//   - uret at SP=0 -> PC_SEL=0.
//   - ecall at full stack -> TRAP_OVF=1, no redirect.
//   VALID=0: IRQ edge captured into PENDING; no redirect until VALID=1.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: turns ecall/uret/CSRRSI/CSRRCI strobes and external IRQ lines
// into next-PC redirects for a single-cycle RISC-V core. It holds the global and
// per-source interrupt enables, the pending and in-service bits, and a nested
// EPC stack with NUM_IRQ+1 entries.
//
// Optional feature macro: IRQ_SYNC_EN
//   defined   -> each IRQ bit passes a 2-flop synchronizer before edge detection
//                (PENDING is set three cycles after the IRQ edge)
//   undefined -> IRQ is edge-detected directly (PENDING is set one cycle later)
//
// Qualifier: VALID marks a retiring instruction. There is no backpressure. When
// VALID is 0, PC_SEL stays 0 and only IRQ edge capture updates state. When VALID
// is 1, exactly one action is chosen, in this priority order: ecall, uret,
// IRQ take, CSR write.
module trap_sequencer #(
    parameter int          NUM_IRQ    = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010,
    parameter logic [31:0] ECALL_VEC  = 32'h0000_0080
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               VALID,
    input  logic               ecall,
    input  logic               uret,
    input  logic               CSRRSI,
    input  logic               CSRRCI,
    input  logic [4:0]         CSR_IMM,
    input  logic [31:0]        NPC,
    input  logic [NUM_IRQ-1:0] IRQ,
    output logic               PC_SEL,
    output logic [31:0]        TARGET,
    output logic               IE,
    output logic [NUM_IRQ-1:0] MIE,
    output logic [NUM_IRQ-1:0] PENDING,
    output logic [NUM_IRQ-1:0] IN_SERVICE,
    output logic               TRAP_OVF
);

    localparam int DEPTH = NUM_IRQ + 1;
    localparam int SP_W  = 3;
    localparam int IDX_W = 2;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_ECALL,
        ACT_ECALL_OVF,
        ACT_URET,
        ACT_URET_NOP,
        ACT_TAKE,
        ACT_CSR
    } action_t;

    action_t            action;
    logic [SP_W-1:0]    sp;
    logic               sp_full;
    logic               sp_empty;

    // Stack storage: each entry holds the return PC, the saved IE, and a tag
    // (ecall flag or IRQ index).
    logic [31:0]        stk_epc   [DEPTH];
    logic               stk_pie   [DEPTH];
    logic               stk_ecall [DEPTH];
    logic [IDX_W-1:0]   stk_idx   [DEPTH];

    logic [31:0]        top_epc;
    logic               top_pie;
    logic               top_ecall;
    logic [IDX_W-1:0]   top_idx;

    logic [NUM_IRQ-1:0] irq_level;
    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] irq_rise;
    logic [NUM_IRQ-1:0] eligible;
    logic               cand_found;
    logic [IDX_W-1:0]   cand_idx;
    logic               cand_ok;
    logic               svc_any;
    logic [IDX_W-1:0]   svc_lo;
    logic [NUM_IRQ-1:0] take_mask;
    logic [NUM_IRQ-1:0] pop_mask;
    logic [NUM_IRQ-1:0] imm_mie;
    logic [31:0]        irq_vec;
    logic               push;

    // When NUM_IRQ < 4, the upper zimm bits have no source enable to drive.
    logic [4:0]         unused_csr_imm;
    assign unused_csr_imm = CSR_IMM;

`ifdef IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] irq_meta;
    logic [NUM_IRQ-1:0] irq_sync;

    // Two-flop synchronizer for the asynchronous IRQ lines.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            irq_meta <= '0;
            irq_sync <= '0;
        end else begin
            irq_meta <= IRQ;
            irq_sync <= irq_meta;
        end
    end

    assign irq_level = irq_sync;
`else
    assign irq_level = IRQ;
`endif

    // IRQ level history for rising-edge detection. Runs every cycle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            irq_prev <= '0;
        end else begin
            irq_prev <= irq_level;
        end
    end

    assign irq_rise = irq_level & ~irq_prev;
    assign eligible = PENDING & MIE;
    assign imm_mie  = CSR_IMM[NUM_IRQ:1];
    assign sp_full  = (sp == SP_W'(DEPTH));
    assign sp_empty = (sp == '0);

    // Find the highest-priority (lowest-index) enabled pending source, and the
    // lowest in-service index. A take must pre-empt everything already on the stack.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        svc_any    = 1'b0;
        svc_lo     = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                cand_found = 1'b1;
                cand_idx   = IDX_W'(i);
            end
            if (IN_SERVICE[i]) begin
                svc_any = 1'b1;
                svc_lo  = IDX_W'(i);
            end
        end
    end

    assign cand_ok = cand_found && (!svc_any || (cand_idx < svc_lo));
    assign irq_vec = VEC_BASE + VEC_STRIDE * {{(32 - IDX_W){1'b0}}, cand_idx};

    // Read the top-of-stack entry (index sp-1).
    always_comb begin
        top_epc   = '0;
        top_pie   = 1'b0;
        top_ecall = 1'b0;
        top_idx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (sp == SP_W'(k + 1)) begin
                top_epc   = stk_epc[k];
                top_pie   = stk_pie[k];
                top_ecall = stk_ecall[k];
                top_idx   = stk_idx[k];
            end
        end
    end

    // Select the single action for this retiring instruction.
    always_comb begin
        action = ACT_NONE;
        if (VALID) begin
            if (ecall) begin
                action = sp_full ? ACT_ECALL_OVF : ACT_ECALL;
            end else if (uret) begin
                action = sp_empty ? ACT_URET_NOP : ACT_URET;
            end else if (IE && cand_ok && !sp_full) begin
                action = ACT_TAKE;
            end else if (CSRRSI || CSRRCI) begin
                action = ACT_CSR;
            end
        end
    end

    // One-hot masks for the source being taken and the source being popped.
    always_comb begin
        take_mask = '0;
        pop_mask  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            take_mask[i] = (action == ACT_TAKE) && (cand_idx == IDX_W'(i));
            pop_mask[i]  = (top_idx == IDX_W'(i));
        end
    end

    assign push = (action == ACT_ECALL) || (action == ACT_TAKE);

    // Redirect into the next-PC mux. TARGET is forced to 0 when there is no redirect.
    always_comb begin
        PC_SEL = 1'b0;
        TARGET = '0;
        case (action)
            ACT_ECALL: begin
                PC_SEL = 1'b1;
                TARGET = ECALL_VEC;
            end
            ACT_URET: begin
                PC_SEL = 1'b1;
                TARGET = top_epc;
            end
            ACT_TAKE: begin
                PC_SEL = 1'b1;
                TARGET = irq_vec;
            end
            default: begin
            end
        endcase
    end

    // Enables, pending/in-service bits, the overflow flag and the stack pointer.
    // Edge capture is ORed in after a take clears its bit, so a new edge on the
    // same cycle keeps PENDING set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            IE         <= 1'b0;
            MIE        <= '0;
            PENDING    <= '0;
            IN_SERVICE <= '0;
            TRAP_OVF   <= 1'b0;
            sp         <= '0;
        end else begin
            PENDING <= (PENDING & ~take_mask) | irq_rise;
            case (action)
                ACT_ECALL: begin
                    IE <= 1'b0;
                    sp <= sp + SP_W'(1);
                end
                ACT_ECALL_OVF: begin
                    TRAP_OVF <= 1'b1;
                end
                ACT_URET: begin
                    IE <= top_pie;
                    sp <= sp - SP_W'(1);
                    if (!top_ecall) begin
                        IN_SERVICE <= IN_SERVICE & ~pop_mask;
                    end
                end
                ACT_TAKE: begin
                    IE         <= 1'b0;
                    sp         <= sp + SP_W'(1);
                    IN_SERVICE <= IN_SERVICE | take_mask;
                end
                ACT_CSR: begin
                    if (CSRRSI) begin
                        IE  <= IE | CSR_IMM[0];
                        MIE <= MIE | imm_mie;
                    end else begin
                        IE  <= IE & ~CSR_IMM[0];
                        MIE <= MIE & ~imm_mie;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Push a new entry at index sp. Reset discards the whole stack.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < DEPTH; k++) begin
                stk_epc[k]   <= '0;
                stk_pie[k]   <= 1'b0;
                stk_ecall[k] <= 1'b0;
                stk_idx[k]   <= '0;
            end
        end else if (push) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (sp == SP_W'(k)) begin
                    stk_epc[k]   <= NPC;
                    stk_pie[k]   <= IE;
                    stk_ecall[k] <= (action == ACT_ECALL);
                    stk_idx[k]   <= (action == ACT_ECALL) ? '0 : cand_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer in its default build
// (NUM_IRQ = 3, no IRQ synchronizer).
// Inputs change 1 ns after the rising edge. Outputs are sampled 2 ns after it.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic        ecall = 1'b0;
    logic        uret = 1'b0;
    logic        csrrsi = 1'b0;
    logic        csrrci = 1'b0;
    logic [4:0]  csr_imm = '0;
    logic [31:0] npc = '0;
    logic [2:0]  irq = '0;
    logic        pc_sel;
    logic [31:0] target;
    logic        ie;
    logic [2:0]  mie;
    logic [2:0]  pending;
    logic [2:0]  in_service;
    logic        trap_ovf;

    int errors = 0;
    int checks = 0;

    trap_sequencer dut (
        .CLK        (clk),
        .RST        (rst),
        .VALID      (valid),
        .ecall      (ecall),
        .uret       (uret),
        .CSRRSI     (csrrsi),
        .CSRRCI     (csrrci),
        .CSR_IMM    (csr_imm),
        .NPC        (npc),
        .IRQ        (irq),
        .PC_SEL     (pc_sel),
        .TARGET     (target),
        .IE         (ie),
        .MIE        (mie),
        .PENDING    (pending),
        .IN_SERVICE (in_service),
        .TRAP_OVF   (trap_ovf)
    );

    // Clock: 10 ns period.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle's instruction inputs, then let combinational outputs settle.
    task automatic drive(input logic v, input logic ec, input logic ur, input logic rsi,
                         input logic rci, input logic [4:0] imm, input logic [31:0] pc);
        valid   = v;
        ecall   = ec;
        uret    = ur;
        csrrsi  = rsi;
        csrrci  = rci;
        csr_imm = imm;
        npc     = pc;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ie", ie, 0);
        check("rst_mie", mie, 0);
        check("rst_pending", pending, 0);
        check("rst_in_service", in_service, 0);
        check("rst_trap_ovf", trap_ovf, 0);
        check("rst_pc_sel", pc_sel, 0);
        check("rst_target", target, 0);
        rst = 1'b0;

        // ecall / uret round trip with IE saved and restored
        drive(1, 0, 0, 1, 0, 5'b00001, 32'h10);
        check("csr_no_redirect", pc_sel, 0);
        adv();
        check("csr_ie_set", ie, 1);
        drive(1, 1, 0, 0, 0, 5'b0, 32'h40);
        check("ecall_pc_sel", pc_sel, 1);
        check("ecall_target", target, 32'h80);
        adv();
        check("ecall_ie_cleared", ie, 0);
        drive(1, 0, 1, 0, 0, 5'b0, 32'h84);
        check("uret_pc_sel", pc_sel, 1);
        check("uret_target", target, 32'h40);
        adv();
        check("uret_ie_restored", ie, 1);
        drive(1, 0, 1, 0, 0, 5'b0, 32'h44);
        check("uret_empty_pc_sel", pc_sel, 0);
        check("uret_empty_target", target, 0);
        adv();

        // Enable all sources and take IRQ1
        drive(1, 0, 0, 1, 0, 5'b01111, 32'h48);
        adv();
        check("mie_all", mie, 3'b111);
        irq = 3'b010;
        drive(1, 0, 0, 0, 0, 5'b0, 32'h200);
        check("irq1_edge_cycle_no_take", pc_sel, 0);
        adv();
        check("irq1_pending", pending, 3'b010);
        drive(1, 0, 0, 0, 0, 5'b0, 32'h200);
        check("irq1_pc_sel", pc_sel, 1);
        check("irq1_target", target, 32'h110);
        adv();
        check("irq1_in_service", in_service, 3'b010);
        check("irq1_ie", ie, 0);
        check("irq1_pending_cleared", pending, 0);

        // Nesting: IRQ0 pre-empts IRQ1 once IE is re-enabled
        drive(1, 0, 0, 1, 0, 5'b00001, 32'h110);
        adv();
        check("nest_ie", ie, 1);
        irq = 3'b011;
        drive(1, 0, 0, 0, 0, 5'b0, 32'h114);
        check("irq0_edge_no_take", pc_sel, 0);
        adv();
        drive(1, 0, 0, 0, 0, 5'b0, 32'h114);
        check("irq0_nest_target", target, 32'h100);
        adv();
        check("nest_in_service", in_service, 3'b011);
        irq = 3'b111;
        drive(1, 0, 0, 0, 0, 5'b0, 32'h104);
        check("irq2_edge_no_take", pc_sel, 0);
        adv();
        check("irq2_pending", pending, 3'b100);
        irq = 3'b000;
        drive(1, 0, 0, 1, 0, 5'b00001, 32'h108);
        adv();
        drive(1, 0, 0, 0, 0, 5'b0, 32'h10c);
        check("irq2_blocked_by_service", pc_sel, 0);
        adv();
        drive(1, 0, 1, 0, 0, 5'b0, 32'h10c);
        check("uret_irq0_target", target, 32'h114);
        adv();
        check("uret_irq0_in_service", in_service, 3'b010);
        check("uret_irq0_ie", ie, 1);
        drive(1, 0, 0, 0, 0, 5'b0, 32'h118);
        check("irq2_still_blocked", pc_sel, 0);
        adv();
        drive(1, 0, 1, 0, 0, 5'b0, 32'h118);
        check("uret_irq1_target", target, 32'h200);
        adv();
        check("uret_irq1_in_service", in_service, 0);
        drive(1, 0, 0, 0, 0, 5'b0, 32'h204);
        check("irq2_take_pc_sel", pc_sel, 1);
        check("irq2_take_target", target, 32'h120);
        adv();
        check("irq2_in_service", in_service, 3'b100);

        // ecall beats a pending IRQ0 that arrives in the same cycle
        drive(1, 0, 0, 1, 0, 5'b00001, 32'h120);
        adv();
        irq = 3'b001;
        drive(1, 0, 0, 0, 0, 5'b0, 32'h208);
        adv();
        irq = 3'b000;
        drive(1, 1, 0, 0, 0, 5'b0, 32'h300);
        check("collide_target", target, 32'h80);
        adv();
        check("collide_pending_kept", pending, 3'b001);

        // Fill the stack (depth 4) and hit the limits
        drive(1, 1, 0, 0, 0, 5'b0, 32'h310);
        adv();
        drive(1, 1, 0, 0, 0, 5'b0, 32'h320);
        check("ecall_fill_target", target, 32'h80);
        adv();
        drive(1, 0, 0, 1, 0, 5'b00001, 32'h84);
        adv();
        check("full_ie", ie, 1);
        drive(1, 0, 0, 0, 0, 5'b0, 32'h88);
        check("full_no_take", pc_sel, 0);
        check("full_pending_kept", pending, 3'b001);
        check("full_take_no_ovf", trap_ovf, 0);
        adv();
        drive(1, 1, 0, 0, 0, 5'b0, 32'h330);
        check("ovf_no_redirect", pc_sel, 0);
        check("ovf_target_zero", target, 0);
        adv();
        check("ovf_sticky", trap_ovf, 1);
        drive(1, 0, 1, 0, 0, 5'b0, 32'h334);
        check("uret_full_target", target, 32'h320);
        adv();
        drive(1, 0, 0, 0, 1, 5'b00110, 32'h324);
        adv();
        check("csrrci_mie", mie, 3'b100);

        // Asynchronous reset while handlers are still stacked
        drive(0, 0, 0, 0, 0, 5'b0, 32'h0);
        rst = 1'b1;
        #1;
        check("arst_ie", ie, 0);
        check("arst_mie", mie, 0);
        check("arst_pending", pending, 0);
        check("arst_in_service", in_service, 0);
        check("arst_trap_ovf", trap_ovf, 0);
        check("arst_pc_sel", pc_sel, 0);
        adv();
        rst = 1'b0;
        drive(1, 0, 1, 0, 0, 5'b0, 32'h400);
        check("arst_sp_zero", pc_sel, 0);
        adv();

        // VALID=0 holds off the redirect but still captures the edge
        drive(1, 0, 0, 1, 0, 5'b00011, 32'h404);
        adv();
        irq = 3'b001;
        drive(0, 0, 0, 0, 0, 5'b0, 32'h408);
        check("stall_edge_no_take", pc_sel, 0);
        adv();
        drive(0, 0, 0, 0, 0, 5'b0, 32'h408);
        check("stall_pending", pending, 3'b001);
        check("stall_no_redirect", pc_sel, 0);
        check("stall_target_zero", target, 0);
        adv();
        drive(1, 0, 0, 0, 0, 5'b0, 32'h500);
        check("stall_release_target", target, 32'h100);
        adv();
        check("stall_in_service", in_service, 3'b001);
        drive(1, 0, 1, 0, 0, 5'b0, 32'h100);
        check("post_reset_uret_target", target, 32'h500);
        adv();
        check("post_reset_in_service", in_service, 0);

        drive(0, 0, 0, 0, 0, 5'b0, 32'h0);
        irq = 3'b000;
        adv();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
